// File: rtl/la_ioseq.sv
// IO ring power sequencer: enables cut-cell-isolated ring segments one at a time in index
// order, waits a settle delay per segment, and powers them down in exactly the reverse order.
module la_ioseq #(
    parameter int NSEG  = 4,
    parameter int CNTW  = 8,
    parameter int RINGW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            clear,
    input  logic [CNTW-1:0] dly,
    input  logic [NSEG-1:0] seg_ok,
    output logic [NSEG-1:0] seg_en,
    output logic            busy,
    output logic            done,
    output logic            fault,
    inout  wire [RINGW-1:0] ioring,
    output logic [2:0]      o_dbg_state
);

    localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSEG - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        UP     = 3'd2,
        DOWN   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t          r_state;
    logic [NSEG-1:0] r_seg_en;
    logic [IDXW-1:0] r_idx;
    logic [CNTW-1:0] r_cnt;

    state_t          w_state_nxt;
    logic [NSEG-1:0] w_seg_en_nxt;
    logic [IDXW-1:0] w_idx_nxt;
    logic [CNTW-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_seg_en <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_seg_en <= w_seg_en_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_seg_en_nxt = r_seg_en;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            IDLE: begin
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    w_seg_en_nxt = NSEG'(1);
                    w_idx_nxt    = '0;
                    w_cnt_nxt    = dly;
                    w_state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (stop) begin
                    w_seg_en_nxt[r_idx] = 1'b0;
                    w_cnt_nxt           = dly;
                    w_state_nxt         = DOWN;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!seg_ok[r_idx]) begin
                    w_seg_en_nxt = '0;
                    w_state_nxt  = FAULT;
                end else if (r_idx == LAST) begin
                    w_state_nxt = UP;
                end else begin
                    w_idx_nxt                    = r_idx + 1'b1;
                    w_seg_en_nxt[r_idx + 1'b1]   = 1'b1;
                    w_cnt_nxt                    = dly;
                end
            end
            UP: begin
                if (stop) begin
                    w_seg_en_nxt[LAST] = 1'b0;
                    w_idx_nxt          = LAST;
                    w_cnt_nxt          = dly;
                    w_state_nxt        = DOWN;
                end else if (!(&(seg_ok & r_seg_en))) begin
                    w_seg_en_nxt = '0;
                    w_state_nxt  = FAULT;
                end
            end
            DOWN: begin
                // Segment r_idx is already off here; wait, then drop the one below it.
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (r_idx == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt                  = r_idx - 1'b1;
                    w_seg_en_nxt[r_idx - 1'b1] = 1'b0;
                    w_cnt_nxt                  = dly;
                end
            end
            FAULT: begin
                w_seg_en_nxt = '0;
                if (clear) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_seg_en_nxt = '0;
                w_state_nxt  = IDLE;
            end
        endcase
    end

    assign seg_en      = r_seg_en;
    assign busy        = (r_state == SETTLE) || (r_state == DOWN);
    assign done        = (r_state == UP);
    assign fault       = (r_state == FAULT);
    assign o_dbg_state = r_state;

endmodule

// File: doc/la_ioseq.md
LA_IOSEQ -- requirements
Module: la_ioseq

Interface
REQ-001 SHALL have parameter NSEG, default 4: number of IO ring segments isolated by cut cells, sequenced in index order.
REQ-002 SHALL have parameter CNTW, default 8: width of the settle-delay counter.
REQ-003 SHALL have parameter RINGW, default 8: width of the generic io-ring interface, passed through unmodified.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1: power-up request, level-sampled.
REQ-007 SHALL have port stop, input, 1: power-down or abort request, level-sampled.
REQ-008 SHALL have port clear, input, 1: fault acknowledge.
REQ-009 SHALL have port dly, input, CNTW: settle delay in cycles, sampled on each counter load.
REQ-010 SHALL have port seg_ok, input, NSEG: per-segment supply-good status from the ring.
REQ-011 SHALL have port seg_en, output, NSEG: per-segment enable to the IO ring segments.
REQ-012 SHALL have port busy, output, 1: high in SETTLE or DOWN.
REQ-013 SHALL have port done, output, 1: high in UP only.
REQ-014 SHALL have port fault, output, 1: high in FAULT only.
REQ-015 SHALL have port ioring, inout, RINGW: generic io-ring interface, with no logic attached in this block.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, UP, DOWN and FAULT, and registered indices idx (ceil log2 NSEG bits, minimum 1) and cnt (CNTW bits).
REQ-017 In IDLE with start=1 and stop=0, the block SHALL set seg_en[0], idx=0 and cnt=dly, and go to SETTLE.
REQ-018 In IDLE with start=1 and stop=1, stop SHALL win and the block SHALL stay in IDLE.
REQ-019 In SETTLE with cnt!=0 and stop=0, the block SHALL decrement cnt.
REQ-020 In SETTLE with cnt==0, seg_ok[idx]=1 and idx<NSEG-1, the block SHALL set idx+1, set seg_en[idx+1] and set cnt=dly.
REQ-021 In SETTLE with cnt==0, seg_ok[idx]=1 and idx==NSEG-1, the block SHALL go to UP.
REQ-022 In SETTLE with cnt==0 and seg_ok[idx]=0, the block SHALL clear seg_en to all zeros and go to FAULT.
REQ-023 Each segment SHALL occupy exactly dly+1 cycles in SETTLE; dly=0 gives one cycle per segment.
REQ-024 In SETTLE with stop=1, the block SHALL abort regardless of cnt: clear seg_en[idx], set cnt=dly and go to DOWN with idx unchanged.
REQ-025 In UP with stop=1, the block SHALL clear seg_en[NSEG-1], set idx=NSEG-1 and cnt=dly, and go to DOWN.
REQ-026 In UP, if any bit of seg_ok & seg_en is 0 and stop=0, the block SHALL clear seg_en and go to FAULT.
REQ-027 In UP, stop SHALL take priority over the fault check in the same cycle.
REQ-028 In DOWN with cnt!=0, the block SHALL decrement cnt.
REQ-029 In DOWN with cnt==0 and idx==0, the block SHALL go to IDLE.
REQ-030 In DOWN with cnt==0 and idx>0, the block SHALL set idx-1, clear seg_en[idx-1] and set cnt=dly.
REQ-031 Disable order in DOWN SHALL be strictly the reverse of enable order.
REQ-032 In DOWN, the block SHALL ignore start, stop and seg_ok.
REQ-033 In FAULT, seg_en SHALL be all zeros; clear=1 SHALL go to IDLE, and start and stop SHALL be ignored.
REQ-034 seg_en SHALL always be thermometer-coded (bits 0..k set, all others 0) or all zeros.
REQ-035 cnt SHALL never wrap: it is only loaded from dly and decremented while nonzero.
REQ-036 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs to outputs.

Reset
REQ-037 With rst=1 at a clock edge, the block SHALL set state=IDLE, seg_en=0, idx=0, cnt=0, busy=0, done=0 and fault=0, overriding all other inputs.
REQ-038 Reset asserted mid-sequence (SETTLE or DOWN) SHALL drop all of seg_en at that same edge, with no reverse sequencing.

Verification
REQ-039 The bench SHALL cover power-up: NSEG=4, dly=3, seg_ok=4'b1111, start pulsed at edge 0 -> seg_en=0001 after edge 1, 0011 after edge 5, 0111 after edge 9, 1111 after edge 13, done=1 after edge 17, busy=1 over edges 1..16.
REQ-040 The bench SHALL cover power-down: from UP with dly=3, stop held 1 cycle -> seg_en=0111 next edge, 0011 four edges later, then 0001, then 0000, then IDLE after a further 4 edges; done=0 from the first edge.
REQ-041 The bench SHALL cover a settle fault: dly=0, seg_ok=4'b1011, start -> seg_en goes 0001, 0011, 0111, then 0000 with fault=1 on the check of idx=2; clear -> IDLE, fault=0.
REQ-042 The bench SHALL cover an abort: dly=5, stop asserted while idx=1, cnt=2 -> seg_en 0011 to 0001 next edge, 0000 six edges later, IDLE six edges after that.
REQ-043 The bench SHALL cover simultaneous and priority events: start+stop together in IDLE -> no change; in UP, stop together with seg_ok[2] dropping -> DOWN, not FAULT; rst in SETTLE at seg_en=0011 -> seg_en=0000 and IDLE at that edge.
REQ-044 The bench SHALL cover the UP fault: from UP, seg_ok[0] dropped for 1 cycle -> seg_en=0000, fault=1, done=0 next edge; stays in FAULT after seg_ok recovers until clear.
